// File: rtl/unidade_controle_if.sv
// Control bundle between the instruction decoder/datapath and unidade_controle.
// master = the control unit, slave = the decoder/datapath side driving strobes and flags.
interface unidade_controle_if;
  logic sNOP, sSTA, sLDA, sADD, sSUB, sAND, sOR, sNOT;
  logic sJ, sJN, sJZ, sIN, sOUT, sSHR, sSHL, sHLT;
  logic sDIR, sIND, sIM, sSOP;
  logic flag_n, flag_z;
  logic ent_valido, sai_pronto;

  logic [1:0] sel_end;
  logic       carga_rem, mem_le, mem_esc, carga_rdm, carga_ri, inc_pc;
  logic       carga_pc, sel_pc, carga_ac, sel_ac;
  logic [2:0] op_ula;
  logic       sel_b, ent_ack, sai_valido, parado, erro_es;

  modport master (
    input  sNOP, sSTA, sLDA, sADD, sSUB, sAND, sOR, sNOT,
           sJ, sJN, sJZ, sIN, sOUT, sSHR, sSHL, sHLT,
           sDIR, sIND, sIM, sSOP, flag_n, flag_z, ent_valido, sai_pronto,
    output sel_end, carga_rem, mem_le, mem_esc, carga_rdm, carga_ri, inc_pc,
           carga_pc, sel_pc, carga_ac, sel_ac, op_ula, sel_b,
           ent_ack, sai_valido, parado, erro_es
  );

  modport slave (
    output sNOP, sSTA, sLDA, sADD, sSUB, sAND, sOR, sNOT,
           sJ, sJN, sJZ, sIN, sOUT, sSHR, sSHL, sHLT,
           sDIR, sIND, sIM, sSOP, flag_n, flag_z, ent_valido, sai_pronto,
    input  sel_end, carga_rem, mem_le, mem_esc, carga_rdm, carga_ri, inc_pc,
           carga_pc, sel_pc, carga_ac, sel_ac, op_ula, sel_b,
           ent_ack, sai_valido, parado, erro_es
  );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control FSM of the 16-bit accumulator processor: fetch, operand
// fetch through REM/RDM, execute, jumps, I/O handshakes with optional timeout, halt.
module unidade_controle #(
  parameter int ESPERA_MAX = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  unidade_controle_if.master     bus,
  output logic [4:0]             estado_dbg
);

  typedef enum logic [4:0] {
    INICIO, B0, B1, B2, DEC, E0, E1, E2, E3, E4, E5,
    EXEC, ESC, SALTO, ENTRADA, SAIDA, PARADO
  } estado_t;

  localparam int CW = (ESPERA_MAX > 1) ? $clog2(ESPERA_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_FIM = CW'((ESPERA_MAX == 0) ? 0 : ESPERA_MAX - 1);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          erro_q, erro_d;
  // Instruction context captured in DEC so the operand chain need not re-read the decoder.
  logic          ind_q, ind_d, imm_q, imm_d, sta_q, sta_d, jmp_q, jmp_d;
  logic [2:0]    op_q, op_d;

  logic eh_carga, eh_unaria, eh_salto, salto_tomado, modo_mem, espera_fim;

  assign eh_carga     = bus.sLDA | bus.sADD | bus.sSUB | bus.sAND | bus.sOR;
  assign eh_unaria    = bus.sNOT | bus.sSHR | bus.sSHL;
  assign eh_salto     = bus.sJ | bus.sJN | bus.sJZ;
  assign salto_tomado = bus.sJ | (bus.sJN & bus.flag_n) | (bus.sJZ & bus.flag_z);
  assign modo_mem     = (bus.sDIR | bus.sIND) & ~bus.sSOP;
  assign espera_fim   = (ESPERA_MAX != 0) && (cnt_q == CNT_FIM);
  assign estado_dbg   = estado_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= INICIO;
      cnt_q    <= '0;
      erro_q   <= 1'b0;
      ind_q    <= 1'b0;
      imm_q    <= 1'b0;
      sta_q    <= 1'b0;
      jmp_q    <= 1'b0;
      op_q     <= 3'd0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      erro_q   <= erro_d;
      ind_q    <= ind_d;
      imm_q    <= imm_d;
      sta_q    <= sta_d;
      jmp_q    <= jmp_d;
      op_q     <= op_d;
    end
  end

  // I/O handshakes: a transfer completes in the cycle where our strobe (ent_ack /
  // sai_valido) and the partner's flag (ent_valido / sai_pronto) are both high.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = '0;
    erro_d   = erro_q;
    ind_d    = ind_q;
    imm_d    = imm_q;
    sta_d    = sta_q;
    jmp_d    = jmp_q;
    op_d     = op_q;

    bus.sel_end    = 2'd0;
    bus.carga_rem  = 1'b0;
    bus.mem_le     = 1'b0;
    bus.mem_esc    = 1'b0;
    bus.carga_rdm  = 1'b0;
    bus.carga_ri   = 1'b0;
    bus.inc_pc     = 1'b0;
    bus.carga_pc   = 1'b0;
    bus.sel_pc     = 1'b0;
    bus.carga_ac   = 1'b0;
    bus.sel_ac     = 1'b0;
    bus.op_ula     = 3'd0;
    bus.sel_b      = 1'b0;
    bus.ent_ack    = 1'b0;
    bus.sai_valido = 1'b0;
    bus.parado     = 1'b0;
    bus.erro_es    = erro_q;

    unique case (estado_q)
      INICIO: estado_d = B0;
      B0: begin
        bus.carga_rem = 1'b1;
        estado_d      = B1;
      end
      B1: begin
        bus.mem_le = 1'b1;
        bus.inc_pc = 1'b1;
        estado_d   = B2;
      end
      B2: begin
        bus.carga_ri = 1'b1;
        estado_d     = DEC;
      end
      DEC: begin
        ind_d = bus.sIND;
        imm_d = bus.sIM;
        sta_d = bus.sSTA;
        jmp_d = 1'b0;
        if      (bus.sADD) op_d = 3'd1;
        else if (bus.sSUB) op_d = 3'd2;
        else if (bus.sAND) op_d = 3'd3;
        else if (bus.sOR)  op_d = 3'd4;
        else if (bus.sNOT) op_d = 3'd5;
        else if (bus.sSHR) op_d = 3'd6;
        else if (bus.sSHL) op_d = 3'd7;
        else               op_d = 3'd0;

        if (bus.sNOP) begin
          estado_d = B0;
        end else if (eh_carga) begin
          if (bus.sIM)        estado_d = EXEC;
          else if (modo_mem)  estado_d = E0;
          else                estado_d = B0;
        end else if (bus.sSTA) begin
          estado_d = modo_mem ? E0 : B0;
        end else if (eh_unaria) begin
          imm_d    = 1'b0;
          estado_d = EXEC;
        end else if (eh_salto) begin
          if (!salto_tomado)              estado_d = B0;
          else if (bus.sIND) begin
            jmp_d    = 1'b1;
            estado_d = E0;
          end else if (bus.sDIR | bus.sIM) estado_d = SALTO;
          else                            estado_d = B0;
        end else if (bus.sIN) begin
          estado_d = ENTRADA;
        end else if (bus.sOUT) begin
          estado_d = SAIDA;
        end else if (bus.sHLT) begin
          estado_d = PARADO;
        end else begin
          estado_d = B0;
        end
      end
      E0: begin
        bus.sel_end   = 2'd1;
        bus.carga_rem = 1'b1;
        estado_d      = (sta_q && !ind_q) ? ESC : E1;
      end
      E1: begin
        bus.mem_le = 1'b1;
        estado_d   = E2;
      end
      E2: begin
        bus.carga_rdm = 1'b1;
        if (jmp_q)      estado_d = SALTO;
        else if (ind_q) estado_d = E3;
        else            estado_d = EXEC;
      end
      E3: begin
        bus.sel_end   = 2'd2;
        bus.carga_rem = 1'b1;
        estado_d      = sta_q ? ESC : E4;
      end
      E4: begin
        bus.mem_le = 1'b1;
        estado_d   = E5;
      end
      E5: begin
        bus.carga_rdm = 1'b1;
        estado_d      = EXEC;
      end
      EXEC: begin
        bus.carga_ac = 1'b1;
        bus.op_ula   = op_q;
        bus.sel_b    = imm_q;
        estado_d     = B0;
      end
      ESC: begin
        bus.mem_esc = 1'b1;
        estado_d    = B0;
      end
      SALTO: begin
        bus.carga_pc = 1'b1;
        bus.sel_pc   = ind_q;
        estado_d     = B0;
      end
      ENTRADA: begin
        cnt_d = cnt_q + CW'(1);
        // A handshake in the last allowed cycle beats the timeout.
        if (bus.ent_valido) begin
          bus.carga_ac = 1'b1;
          bus.sel_ac   = 1'b1;
          bus.ent_ack  = 1'b1;
          estado_d     = B0;
        end else if (espera_fim) begin
          erro_d   = 1'b1;
          estado_d = B0;
        end
      end
      SAIDA: begin
        cnt_d          = cnt_q + CW'(1);
        bus.sai_valido = 1'b1;
        if (bus.sai_pronto) begin
          estado_d = B0;
        end else if (espera_fim) begin
          erro_d   = 1'b1;
          estado_d = B0;
        end
      end
      PARADO: bus.parado = 1'b1;
      default: estado_d = INICIO;
    endcase
  end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control state machine for the 16-bit accumulator processor. Sits directly downstream of the instruction decoder: it consumes the decoder's one-hot opcode and addressing-mode strobes, together with the accumulator flags and the I/O handshakes. It drives every load, select and memory strobe of the datapath through the fetch, operand-fetch and execute phases.

## Interface
Parameters:
- ESPERA_MAX, default 0: I/O wait limit in cycles; 0 = wait forever.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- sNOP,sSTA,sLDA,sADD,sSUB,sAND,sOR,sNOT,sJ,sJN,sJZ,sIN,sOUT,sSHR,sSHL,sHLT  input  1 each  one-hot opcode strobes from the decoder
- sDIR,sIND,sIM,sSOP  input  1 each  one-hot addressing-mode strobes from the decoder
- flag_n, flag_z  input  1  AC negative / AC zero
- ent_valido  input  1  input port has data
- sai_pronto  input  1  output port accepts AC
- sel_end  output  2  REM source: 0 PC, 1 RI[8:0], 2 RDM
- carga_rem  output  1  load REM
- mem_le  output  1  memory read; data valid next cycle
- mem_esc  output  1  write AC to mem[REM]
- carga_rdm  output  1  load RDM from memory data
- carga_ri  output  1  load RI from memory data
- inc_pc  output  1  PC <= PC+1
- carga_pc, sel_pc  output  1, 1  load PC from RI[8:0] (sel_pc=0) or RDM (sel_pc=1)
- carga_ac, sel_ac  output  1, 1  load AC from ULA (0) or input port (1)
- op_ula  output  3  0 PASS_B, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT, 6 SHR, 7 SHL
- sel_b  output  1  ULA B operand: 0 RDM, 1 RI[8:0] zero-extended
- ent_ack, sai_valido  output  1  I/O handshake
- parado  output  1  processor halted
- erro_es  output  1  sticky I/O timeout flag

## Operation
- States: INICIO, B0, B1, B2, DEC, E0–E5, EXEC, ESC, SALTO, ENTRADA, SAIDA, PARADO.
- All outputs are decoded from the current state (and the strobes in DEC/EXEC). Any output not listed for a state is 0.
- INICIO: no outputs → B0.
- Fetch:
  - B0: sel_end=0, carga_rem.
  - B1: mem_le, inc_pc.
  - B2: carga_ri.
  - Then DEC. Decoder strobes are valid in DEC; flags are sampled in DEC.
- DEC dispatch:
  - NOP → B0.
  - LDA/ADD/SUB/AND/OR: IM → EXEC (sel_b=1); DIR/IND → E0; SOP → B0 (as NOP).
  - STA: DIR → E0 then ESC; IND → E0; IM/SOP → B0.
  - NOT/SHR/SHL → EXEC; mode is ignored.
  - Jumps: taken if J, JN&flag_n, or JZ&flag_z. If not taken → B0.
    - Taken, DIR/IM → SALTO with sel_pc=0.
    - Taken, IND → E0..E2, then SALTO with sel_pc=1.
    - Taken, SOP → B0.
  - IN → ENTRADA; OUT → SAIDA; HLT → PARADO.
- Operand chain:
  - E0: sel_end=1, carga_rem.
  - E1: mem_le.
  - E2: carga_rdm.
  - E3: sel_end=2, carga_rem.
  - E4: mem_le.
  - E5: carga_rdm.
  - DIR loads exit after E2 (→ EXEC, sel_b=0). IND loads exit after E5.
  - STA DIR: E0 → ESC. STA IND: E0, E1, E2, E3 → ESC.
- EXEC: carga_ac, sel_ac=0, op_ula per opcode → B0.
- ESC: mem_esc → B0.
- SALTO: carga_pc → B0.
- ENTRADA: while ent_valido=0, hold. Cycle with ent_valido=1: carga_ac, sel_ac=1, ent_ack → B0.
- SAIDA: sai_valido held high; on sai_pronto=1 → B0.
- Timeout: a wait counter counts cycles spent in ENTRADA/SAIDA. If ESPERA_MAX≠0 and the counter reaches ESPERA_MAX without a handshake, set erro_es → B0. The counter clears on entry to the state.
- PARADO: parado=1 forever; only reset exits.

## Timing
- rst_n low: state INICIO, erro_es=0, wait counter 0, all outputs 0, regardless of clk. Reset mid-instruction aborts it with no further strobes.
- First B0 in the first cycle after rst_n rises plus one (INICIO lasts one cycle).
- Cycles from B0 to next B0:
  - NOP, not-taken jump, illegal mode: 4
  - NOT/SHR/SHL, IM load, J DIR/IM: 5
  - STA DIR: 6
  - DIR load, J IND: 8
  - STA IND: 9
  - IND load: 11
  - IN/OUT: 5 + wait cycles
- Timeout: exactly ESPERA_MAX cycles in SAIDA/ENTRADA, then B0. erro_es rises on the same edge as the transition to B0.
- ent_ack is a one-cycle pulse coincident with carga_ac. A handshake arriving in the final timeout cycle wins over the timeout.

## Test plan
- Reset release, decoder strobes sNOP+sSOP: INICIO 1 cycle; carga_rem at cycle 1, mem_le+inc_pc at cycle 2, carga_ri at cycle 3, B0 again at cycle 5.
- sLDA+sIND: sel_end sequence 0,1,2 on successive carga_rem pulses; carga_ac with op_ula=0, sel_b=0 exactly 10 cycles after B0.
- sJN+sDIR: with flag_n=0, no carga_pc and B0 after 4 cycles. With flag_n=1, carga_pc=1, sel_pc=0 in cycle 5.
- sIN, ent_valido raised 3 cycles after entering ENTRADA: no strobes during the wait; then one cycle of ent_ack=carga_ac=sel_ac=1.
- ESPERA_MAX=4, sOUT, sai_pronto held 0: sai_valido high 4 cycles, then erro_es=1 and B0. erro_es stays 1 through the next instruction.
- sHLT: parado=1 for 100 cycles with no other strobes. rst_n pulsed low mid-PARADO → parado=0 asynchronously, fetch restarts.
